fifo_burst_writer: RTL and testbench



---
 rtl/fifo_bench_pkg.sv | 19 +
 rtl/stall_run_tracker.sv | 58 +++++
 rtl/fifo_burst_writer.sv | 131 +++++++++++++
 tb/tb_fifo_burst_writer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_bench_pkg.sv
// Shared types and helpers for the FIFO throughput bench producer.
// Holds the writer state encoding, the default counter width and the saturating increment.
package fifo_bench_pkg;

    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } wr_state_e;

    // Operates on 32 bits so one helper serves every counter width; callers cast back.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/stall_run_tracker.sv
// Backpressure statistics: total stall cycles, current stall run and longest run seen.
// The maximum is updated in the same cycle the run grows, so it is current during an open run.
module stall_run_tracker
    import fifo_bench_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             stall_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] max_stall_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] run_inc;

    always_comb begin
        total_d = total_q;
        run_d   = run_q;
        max_d   = max_q;
        run_inc = CNT_W'(sat_inc(32'(run_q), 32'(CNT_MAX)));
        if (clear_i) begin
            total_d = '0;
            run_d   = '0;
            max_d   = '0;
        end else if (stall_i) begin
            total_d = CNT_W'(sat_inc(32'(total_q), 32'(CNT_MAX)));
            run_d   = run_inc;
            if (run_inc > max_q) begin
                max_d = run_inc;
            end
        end else begin
            run_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            total_q <= '0;
            run_q   <= '0;
            max_q   <= '0;
        end else begin
            total_q <= total_d;
            run_q   <= run_d;
            max_q   <= max_d;
        end
    end

    assign stall_cnt_o = total_q;
    assign max_stall_o = max_q;

endmodule

// File: rtl/fifo_burst_writer.sv
// Burst/gap write-pattern generator for a FIFO write port, with backpressure statistics.
//   state | meaning
//   IDLE  | waiting for start_i after reset
//   BURST | writing; each cycle with wr_rdy_i=1 is an accepted write, wr_rdy_i=0 is a stall
//   GAP   | IDLE_CYCLES idle cycles between bursts, wr_rdy_i ignored
//   DONE  | NUM_BURSTS bursts written, statistics held until start_i
module fifo_burst_writer
    import fifo_bench_pkg::*;
#(
    parameter int BURST_LEN   = 4,
    parameter int IDLE_CYCLES = 2,
    parameter int NUM_BURSTS  = 3,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             wr_rdy_i,
    output logic             we_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] words_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] max_stall_o
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'((NUM_BURSTS > 0) ? NUM_BURSTS - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);

    wr_state_e        state_q, state_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic accept;
    logic stall;
    logic start_fire;

    assign accept     = (state_q == BURST) && wr_rdy_i;
    assign stall      = (state_q == BURST) && !wr_rdy_i;
    assign start_fire = ((state_q == IDLE) || (state_q == DONE)) && start_i;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        burst_d = burst_q;
        words_d = words_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = BURST;
                    beat_d  = '0;
                    gap_d   = '0;
                    burst_d = '0;
                    words_d = '0;
                end
            end
            BURST: begin
                if (accept) begin
                    words_d = CNT_W'(sat_inc(32'(words_q), 32'(CNT_MAX)));
                    if (beat_q == BEAT_LAST) begin
                        beat_d  = '0;
                        burst_d = CNT_W'(sat_inc(32'(burst_q), 32'(CNT_MAX)));
                        if ((NUM_BURSTS != 0) && (burst_q == BURST_LAST)) begin
                            state_d = DONE;
                        end else if (IDLE_CYCLES > 0) begin
                            state_d = GAP;
                            gap_d   = GAP_LOAD;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            GAP: begin
                // Down-counter loaded with IDLE_CYCLES-1; terminal count ends the gap.
                if (gap_q == '0) begin
                    state_d = BURST;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == BURST) || (state_d == GAP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            gap_q   <= '0;
            burst_q <= '0;
            words_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            burst_q <= burst_d;
            words_q <= words_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    stall_run_tracker #(
        .CNT_W (CNT_W)
    ) u_stall_run_tracker (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (start_fire),
        .stall_i     (stall),
        .stall_cnt_o (stall_cnt_o),
        .max_stall_o (max_stall_o)
    );

    assign we_o    = accept;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign words_o = words_q;

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Directed bench for fifo_burst_writer: four instances cover default, back-to-back,
// saturating and free-running configurations.
module tb_fifo_burst_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start_a = 1'b0, rdy_a = 1'b1, we_a, busy_a, done_a;
    logic [15:0] words_a, stall_a, max_a;
    logic        start_b = 1'b0, rdy_b = 1'b1, we_b, busy_b, done_b;
    logic [15:0] words_b, stall_b, max_b;
    logic        start_s = 1'b0, rdy_s = 1'b1, we_s, busy_s, done_s;
    logic [2:0]  words_s, stall_s, max_s;
    logic        start_n = 1'b0, rdy_n = 1'b1, we_n, busy_n, done_n;
    logic [15:0] words_n, stall_n, max_n;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_burst_writer dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .wr_rdy_i(rdy_a), .we_o(we_a),
        .busy_o(busy_a), .done_o(done_a), .words_o(words_a), .stall_cnt_o(stall_a),
        .max_stall_o(max_a)
    );

    fifo_burst_writer #(.BURST_LEN(2), .IDLE_CYCLES(0), .NUM_BURSTS(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .wr_rdy_i(rdy_b), .we_o(we_b),
        .busy_o(busy_b), .done_o(done_b), .words_o(words_b), .stall_cnt_o(stall_b),
        .max_stall_o(max_b)
    );

    fifo_burst_writer #(.CNT_W(3), .NUM_BURSTS(0)) dut_s (
        .clk_i(clk), .rst_i(rst), .start_i(start_s), .wr_rdy_i(rdy_s), .we_o(we_s),
        .busy_o(busy_s), .done_o(done_s), .words_o(words_s), .stall_cnt_o(stall_s),
        .max_stall_o(max_s)
    );

    fifo_burst_writer #(.NUM_BURSTS(0)) dut_n (
        .clk_i(clk), .rst_i(rst), .start_i(start_n), .wr_rdy_i(rdy_n), .we_o(we_n),
        .busy_o(busy_n), .done_o(done_n), .words_o(words_n), .stall_cnt_o(stall_n),
        .max_stall_o(max_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Cycle c is the interval after edge c; start_a is sampled at edge 0.
    task automatic run_a(input int ncyc, input logic [31:0] low_m, input logic [31:0] we_m,
                         input logic [31:0] busy_m, input int done_from, input int gap_start);
        @(negedge clk);
        start_a = 1'b1;
        rdy_a   = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start_a = (c == gap_start);
            rdy_a   = !low_m[c];
            #1;
            chk($sformatf("a_we c%0d", c), {31'd0, we_a}, {31'd0, we_m[c]});
            chk($sformatf("a_we_vs_rdy c%0d", c), {31'd0, we_a & ~rdy_a}, 32'd0);
            chk($sformatf("a_busy c%0d", c), {31'd0, busy_a}, {31'd0, busy_m[c]});
            chk($sformatf("a_done c%0d", c), {31'd0, done_a}, 32'(c >= done_from));
            if (c == 1) begin
                chk("a_words_cleared", 32'(words_a), 32'd0);
                chk("a_stall_cleared", 32'(stall_a), 32'd0);
                chk("a_max_cleared", 32'(max_a), 32'd0);
            end
        end
        start_a = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_we", {31'd0, we_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_words", 32'(words_a), 32'd0);
        chk("rst_stall", 32'(stall_a), 32'd0);
        chk("rst_max", 32'(max_a), 32'd0);
        rst = 1'b0;

        // Backpressure: ready low in cycles 2-4 (burst 1), 8 (gap, not a stall), 11 (burst 2).
        run_a(22, 32'h0000_091C, 32'h001E_74E2, 32'h001F_FFFE, 21, 0);
        chk("bp_words", 32'(words_a), 32'd12);
        chk("bp_stall", 32'(stall_a), 32'd4);
        chk("bp_max", 32'(max_a), 32'd3);

        // Free flow restarted from DONE; start_i pulsed in gap cycle 5 must be ignored.
        run_a(18, 32'h0, 32'h0001_E79E, 32'h0001_FFFE, 17, 5);
        chk("ff_words", 32'(words_a), 32'd12);
        chk("ff_stall", 32'(stall_a), 32'd0);
        chk("ff_max", 32'(max_a), 32'd0);

        // Reset in cycle 3 of the first burst.
        @(negedge clk);
        start_a = 1'b1;
        rdy_a   = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        rdy_a = 1'b0;
        @(negedge clk);
        rdy_a = 1'b1;
        rst   = 1'b1;
        #1;
        chk("mr_we_before", {31'd0, we_a}, 32'd1);
        chk("mr_words_before", 32'(words_a), 32'd1);
        chk("mr_stall_before", 32'(stall_a), 32'd1);
        chk("mr_max_before", 32'(max_a), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_we", {31'd0, we_a}, 32'd0);
        chk("mr_busy", {31'd0, busy_a}, 32'd0);
        chk("mr_done", {31'd0, done_a}, 32'd0);
        chk("mr_words", 32'(words_a), 32'd0);
        chk("mr_stall", 32'(stall_a), 32'd0);
        chk("mr_max", 32'(max_a), 32'd0);
        @(negedge clk);
        #1;
        chk("mr_we_later", {31'd0, we_a}, 32'd0);

        // Back-to-back: two bursts of two with no gap.
        @(negedge clk);
        start_b = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start_b = 1'b0;
            #1;
            chk($sformatf("b2b_we c%0d", c), {31'd0, we_b}, 32'(c <= 4));
            chk($sformatf("b2b_done c%0d", c), {31'd0, done_b}, 32'(c >= 5));
        end
        chk("b2b_words", 32'(words_b), 32'd4);

        // Saturation at CNT_W=3 with ten stalled burst cycles.
        @(negedge clk);
        start_s = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start_s = 1'b0;
            rdy_s   = (c > 10);
            #1;
            chk($sformatf("sat_stall c%0d", c), 32'(stall_s), (c - 1 > 7) ? 32'd7 : 32'(c - 1));
            chk($sformatf("sat_max c%0d", c), 32'(max_s), (c - 1 > 7) ? 32'd7 : 32'(c - 1));
        end
        chk("sat_words", 32'(words_s), 32'd0);

        // Free-running: 100 cycles of ready, expected write at (c-1)%6 < 4.
        @(negedge clk);
        start_n = 1'b1;
        begin
            int exp_words;
            exp_words = 0;
            for (int c = 1; c <= 100; c++) begin
                @(negedge clk);
                start_n = 1'b0;
                #1;
                chk($sformatf("inf_words c%0d", c), 32'(words_n), 32'(exp_words));
                chk($sformatf("inf_we c%0d", c), {31'd0, we_n}, 32'(((c - 1) % 6) < 4));
                chk($sformatf("inf_done c%0d", c), {31'd0, done_n}, 32'd0);
                if (((c - 1) % 6) < 4) exp_words++;
            end
        end
        @(negedge clk);
        rdy_n = 1'b0;
        #1;
        chk("inf_words_final", 32'(words_n), 32'd68);
        chk("inf_done_final", {31'd0, done_n}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
